// File: rtl/ip_packet_rx_wide.sv
// Ethernet/IPv4 receive parser at 1/2/4/8 bytes per beat, holding one fixed-size payload for the accelerator.
// Define RX_STATS_EN to build the good / busy-drop / error-drop counters; otherwise the stat ports read 0.

module ip_packet_rx_wide_lane #(
    parameter int LANE            = 0,
    parameter int COUNT_WIDTH     = 16,
    parameter int USER_DATA_BYTES = 785,
    parameter int PIW             = 10
) (
    input  logic [COUNT_WIDTH-1:0] pos,
    input  logic                   keep,
    output logic                   eth_we,
    output logic                   ip_we,
    output logic                   pl_we,
    output logic [3:0]             eth_idx,
    output logic [4:0]             ip_idx,
    output logic [PIW-1:0]         pl_idx
);
    logic [31:0] idx;

    always_comb begin
        idx     = 32'(pos) + 32'(LANE);
        eth_we  = keep && (idx < 32'd14);
        ip_we   = keep && (idx >= 32'd14) && (idx < 32'd34);
        pl_we   = keep && (idx >= 32'd34) && (idx < 32'(34 + USER_DATA_BYTES));
        eth_idx = idx[3:0];
        ip_idx  = 5'(idx - 32'd14);
        pl_idx  = PIW'(idx - 32'd34);
    end
endmodule

module ip_packet_rx_wide #(
    parameter int USER_DATA_BYTES = 785,
    parameter int BYTES_PER_BEAT  = 1,
    parameter bit CHECK_MAC       = 1'b1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
    input  logic [8*BYTES_PER_BEAT-1:0]  MAC_TDATA,
    input  logic [BYTES_PER_BEAT-1:0]    MAC_TKEEP,
    input  logic                         MAC_TVALID,
    output logic                         MAC_TREADY,
    input  logic                         MAC_TLAST,
    input  logic                         MAC_TUSER,
    output logic [8*USER_DATA_BYTES-1:0] DATA_FRAME,
    output logic [31:0]                  SRC_IP_ADDRESS,
    output logic [47:0]                  SRC_MAC_ADDRESS,
    output logic                         FRAME_VALID,
    input  logic                         FRAME_READY,
    output logic                         PACKET_FOR_ACCELERATOR,
    output logic [15:0]                  STAT_GOOD,
    output logic [15:0]                  STAT_DROP_BUSY,
    output logic [15:0]                  STAT_DROP_ERR
);
    localparam int FRAME_BYTES = 34 + USER_DATA_BYTES;
    localparam int PIW = (USER_DATA_BYTES > 1) ? $clog2(USER_DATA_BYTES) : 1;

    typedef enum logic [1:0] {START, RECV, DISCARD, EVAL} state_t;

    state_t                              state;
    logic [COUNT_WIDTH-1:0]              pos;
    logic [COUNT_WIDTH:0]                pos_sum;
    logic [COUNT_WIDTH-1:0]              pos_next;
    logic [13:0][7:0]                    eth_hdr;
    logic [19:0][7:0]                    ip_hdr;
    logic [USER_DATA_BYTES-1:0][7:0]     payload;
    logic                                len_ok, fcs_ok;
    logic                                beat, busy_start, capture;
    logic                                ip_match, mac_ok, pkt_pass;

    logic [BYTES_PER_BEAT-1:0][7:0]      lane_data;
    logic [BYTES_PER_BEAT-1:0]           eth_we, ip_we, pl_we;
    logic [BYTES_PER_BEAT-1:0][3:0]      eth_idx;
    logic [BYTES_PER_BEAT-1:0][4:0]      ip_idx;
    logic [BYTES_PER_BEAT-1:0][PIW-1:0]  pl_idx;

    assign beat       = MAC_TVALID && MAC_TREADY;
    // A frame still waiting for the accelerator makes the whole next packet a drop.
    assign busy_start = (pos == '0) && FRAME_VALID;
    assign capture    = beat && (state == RECV) && !busy_start;
    assign lane_data  = MAC_TDATA;

    always_comb begin
        pos_sum = {1'b0, pos};
        for (int n = 0; n < BYTES_PER_BEAT; n++)
            pos_sum = pos_sum + {{COUNT_WIDTH{1'b0}}, MAC_TKEEP[n]};
        pos_next = pos_sum[COUNT_WIDTH] ? '1 : pos_sum[COUNT_WIDTH-1:0];
    end

    for (genvar n = 0; n < BYTES_PER_BEAT; n++) begin : g_lane
        ip_packet_rx_wide_lane #(
            .LANE(n), .COUNT_WIDTH(COUNT_WIDTH),
            .USER_DATA_BYTES(USER_DATA_BYTES), .PIW(PIW)
        ) u_lane (
            .pos(pos), .keep(MAC_TKEEP[n]),
            .eth_we(eth_we[n]), .ip_we(ip_we[n]), .pl_we(pl_we[n]),
            .eth_idx(eth_idx[n]), .ip_idx(ip_idx[n]), .pl_idx(pl_idx[n])
        );
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            eth_hdr <= '0;
            ip_hdr  <= '0;
            payload <= '0;
        end else if (capture) begin
            for (int n = 0; n < BYTES_PER_BEAT; n++) begin
                if (eth_we[n]) eth_hdr[eth_idx[n]] <= lane_data[n];
                if (ip_we[n])  ip_hdr[ip_idx[n]]   <= lane_data[n];
                if (pl_we[n])  payload[pl_idx[n]]  <= lane_data[n];
            end
        end
    end

    assign ip_match = (ip_hdr[19:16] == ACCELERATOR_IP_ADDRESS);
    assign mac_ok   = !CHECK_MAC || (eth_hdr[5:0] == ACCELERATOR_MAC_ADDRESS) || (&eth_hdr[5:0]);
    assign pkt_pass = len_ok && fcs_ok && (eth_hdr[12] == 8'h08) && (eth_hdr[13] == 8'h00)
                      && (ip_hdr[0] == 8'h45) && ip_match && mac_ok;

    assign PACKET_FOR_ACCELERATOR = ip_match;
    assign DATA_FRAME      = payload;
    assign SRC_IP_ADDRESS  = ip_hdr[15:12];
    assign SRC_MAC_ADDRESS = eth_hdr[11:6];

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state       <= START;
            MAC_TREADY  <= 1'b0;
            pos         <= '0;
            len_ok      <= 1'b0;
            fcs_ok      <= 1'b0;
            FRAME_VALID <= 1'b0;
        end else begin
            if (FRAME_VALID && FRAME_READY) FRAME_VALID <= 1'b0;
            case (state)
                START: begin
                    state      <= RECV;
                    MAC_TREADY <= 1'b1;
                end
                RECV: if (beat) begin
                    pos <= pos_next;
                    if (busy_start) begin
                        if (MAC_TLAST) pos <= '0;
                        else state <= DISCARD;
                    end else if (MAC_TLAST) begin
                        len_ok     <= (pos_next == COUNT_WIDTH'(FRAME_BYTES));
                        fcs_ok     <= !MAC_TUSER;
                        state      <= EVAL;
                        MAC_TREADY <= 1'b0;
                    end
                end
                DISCARD: if (beat) begin
                    pos <= pos_next;
                    if (MAC_TLAST) begin
                        pos   <= '0;
                        state <= RECV;
                    end
                end
                EVAL: begin
                    if (pkt_pass) FRAME_VALID <= 1'b1;
                    pos        <= '0;
                    state      <= RECV;
                    MAC_TREADY <= 1'b1;
                end
                default: state <= START;
            endcase
        end
    end

`ifdef RX_STATS_EN
    logic eval_good, eval_bad, busy_drop;

    assign eval_good = (state == EVAL) && pkt_pass;
    assign eval_bad  = (state == EVAL) && !pkt_pass;
    assign busy_drop = (state == RECV) && beat && busy_start;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            STAT_GOOD      <= '0;
            STAT_DROP_BUSY <= '0;
            STAT_DROP_ERR  <= '0;
        end else begin
            if (eval_good && STAT_GOOD != 16'hFFFF)      STAT_GOOD      <= STAT_GOOD + 16'd1;
            if (busy_drop && STAT_DROP_BUSY != 16'hFFFF) STAT_DROP_BUSY <= STAT_DROP_BUSY + 16'd1;
            if (eval_bad && STAT_DROP_ERR != 16'hFFFF)   STAT_DROP_ERR  <= STAT_DROP_ERR + 16'd1;
        end
    end
`else
    assign STAT_GOOD      = '0;
    assign STAT_DROP_BUSY = '0;
    assign STAT_DROP_ERR  = '0;
`endif
endmodule

// File: tb/tb_ip_packet_rx_wide.sv
// Bench for ip_packet_rx_wide: a 1-byte and a 4-byte instance receive the same packets side by side.
module tb_ip_packet_rx_wide;
    localparam int UDB = 785;
    localparam int FB  = 34 + UDB;
    localparam logic [31:0] OWN_IP  = 32'h0200000A;        // 10.0.0.2
    localparam logic [47:0] OWN_MAC = 48'h010000000002;    // 02:00:00:00:00:01
`ifdef RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst    [2];
    logic [31:0]          tdata  [2];
    logic [3:0]           tkeep  [2];
    logic                 tvalid [2];
    logic                 tready [2];
    logic                 tlast  [2];
    logic                 tuser  [2];
    logic [8*UDB-1:0]     frame  [2];
    logic [31:0]          src_ip [2];
    logic [47:0]          src_mac[2];
    logic                 fv     [2];
    logic                 pfa    [2];
    logic [15:0]          sg     [2];
    logic [15:0]          sb     [2];
    logic [15:0]          se     [2];
    logic                 frame_ready;

    ip_packet_rx_wide #(.USER_DATA_BYTES(UDB), .BYTES_PER_BEAT(1), .CHECK_MAC(1'b1), .COUNT_WIDTH(16)) dut1 (
        .ACLK(clk), .ARESET(rst[0]),
        .ACCELERATOR_IP_ADDRESS(OWN_IP), .ACCELERATOR_MAC_ADDRESS(OWN_MAC),
        .MAC_TDATA(tdata[0][7:0]), .MAC_TKEEP(tkeep[0][0:0]), .MAC_TVALID(tvalid[0]),
        .MAC_TREADY(tready[0]), .MAC_TLAST(tlast[0]), .MAC_TUSER(tuser[0]),
        .DATA_FRAME(frame[0]), .SRC_IP_ADDRESS(src_ip[0]), .SRC_MAC_ADDRESS(src_mac[0]),
        .FRAME_VALID(fv[0]), .FRAME_READY(frame_ready), .PACKET_FOR_ACCELERATOR(pfa[0]),
        .STAT_GOOD(sg[0]), .STAT_DROP_BUSY(sb[0]), .STAT_DROP_ERR(se[0])
    );

    ip_packet_rx_wide #(.USER_DATA_BYTES(UDB), .BYTES_PER_BEAT(4), .CHECK_MAC(1'b1), .COUNT_WIDTH(16)) dut4 (
        .ACLK(clk), .ARESET(rst[1]),
        .ACCELERATOR_IP_ADDRESS(OWN_IP), .ACCELERATOR_MAC_ADDRESS(OWN_MAC),
        .MAC_TDATA(tdata[1]), .MAC_TKEEP(tkeep[1]), .MAC_TVALID(tvalid[1]),
        .MAC_TREADY(tready[1]), .MAC_TLAST(tlast[1]), .MAC_TUSER(tuser[1]),
        .DATA_FRAME(frame[1]), .SRC_IP_ADDRESS(src_ip[1]), .SRC_MAC_ADDRESS(src_mac[1]),
        .FRAME_VALID(fv[1]), .FRAME_READY(frame_ready), .PACKET_FOR_ACCELERATOR(pfa[1]),
        .STAT_GOOD(sg[1]), .STAT_DROP_BUSY(sb[1]), .STAT_DROP_ERR(se[1])
    );

    int checks = 0;
    int failures = 0;

    // Model state: the packet on the wire and what the receiver should be holding.
    logic [7:0]       pkt[$];
    bit               held, pending, cmp_en;
    logic [8*UDB-1:0] exp_frame;
    logic [8*UDB-1:0] zero_frame;
    logic [31:0]      exp_ip;
    logic [47:0]      exp_mac;
    int               n_good, n_busy, n_err;

    function automatic void chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endfunction

    function automatic void chk_frame(input string name, input int k, input logic [8*UDB-1:0] act,
                                      input logic [8*UDB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < UDB; i++)
                if (act[8*i+:8] !== exp[8*i+:8]) begin
                    $display("FAIL %s dut%0d byte %0d actual=%0h required=%0h", name, k, i,
                             act[8*i+:8], exp[8*i+:8]);
                    break;
                end
        end
    endfunction

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] ver,
                         input logic [31:0] dip, input int plen, input logic [7:0] seed);
        logic [47:0] smac;
        logic [31:0] sip;
        smac = 48'h554433221100;   // 00:11:22:33:44:55
        sip  = 32'h0100A8C0;       // 192.168.0.1
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back(dmac[8*i+:8]);
        for (int i = 0; i < 6; i++) pkt.push_back(smac[8*i+:8]);
        pkt.push_back(etype[15:8]);
        pkt.push_back(etype[7:0]);
        pkt.push_back(ver);
        for (int i = 1; i < 12; i++) pkt.push_back(8'(i));
        for (int i = 0; i < 4; i++) pkt.push_back(sip[8*i+:8]);
        for (int i = 0; i < 4; i++) pkt.push_back(dip[8*i+:8]);
        for (int i = 0; i < plen; i++) pkt.push_back(8'(seed + 8'(i * 3)));
    endtask

    function automatic bit model_pass(input bit fcs_bad);
        logic [31:0] dip;
        logic [47:0] dmac;
        if (pkt.size() != FB) return 1'b0;
        dip  = {pkt[33], pkt[32], pkt[31], pkt[30]};
        dmac = {pkt[5], pkt[4], pkt[3], pkt[2], pkt[1], pkt[0]};
        return !fcs_bad && pkt[12] == 8'h08 && pkt[13] == 8'h00 && pkt[14] == 8'h45
               && dip == OWN_IP && (dmac == OWN_MAC || dmac == 48'hFFFFFFFFFFFF);
    endfunction

    task automatic send(input int k, input bit user, input int rst_at, input bit lat, output int stalls);
        int idx, bpb, guard;
        bit rst_done;
        logic [31:0] d;
        logic [3:0]  m;
        idx = 0; rst_done = 0; stalls = 0;
        bpb = (k == 0) ? 1 : 4;
        while (idx < pkt.size()) begin
            if (rst_at >= 0 && !rst_done && idx >= rst_at) begin
                rst_done = 1;
                tvalid[k] = 1'b0;
                rst[k] = 1'b0;
                #1;
                chk("rst_mid_fv", k, fv[k], 0);
                chk("rst_mid_tready", k, tready[k], 0);
                chk_frame("rst_mid_frame", k, frame[k], zero_frame);
                chk("rst_mid_src_ip", k, src_ip[k], 0);
                chk("rst_mid_src_mac", k, src_mac[k], 0);
                chk("rst_mid_pfa", k, pfa[k], 0);
                chk("rst_mid_stats", k, {sg[k], sb[k], se[k]}, 0);
                @(posedge clk); #1;
                rst[k] = 1'b1;
            end
            d = '0; m = '0;
            for (int n = 0; n < bpb; n++)
                if (idx + n < pkt.size()) begin
                    d[8*n+:8] = pkt[idx+n];
                    m[n] = 1'b1;
                end
            tdata[k]  = d;
            tkeep[k]  = m;
            tlast[k]  = (idx + bpb >= pkt.size());
            tuser[k]  = user && tlast[k];
            tvalid[k] = 1'b1;
            guard = 0;
            forever begin
                @(negedge clk);
                if (tready[k]) break;
                stalls++;
                guard++;
                if (guard == 20) break;
            end
            if (guard == 20) begin
                checks++; failures++;
                $display("FAIL tready_timeout dut%0d at byte %0d", k, idx);
                break;
            end
            @(posedge clk); #1;
            if (lat && tlast[k]) begin
                chk("lat_tlast_edge", k, fv[k], 0);
                @(posedge clk); @(posedge clk); #1;
                chk("lat_second_edge", k, fv[k], 1);
            end
            idx += bpb;
        end
        tvalid[k] = 1'b0;
        tlast[k]  = 1'b0;
        tuser[k]  = 1'b0;
    endtask

    task automatic run(input string name, input bit user, input bit exp_acc, input int rst_at, input bit lat);
        bit busy, pass, acc;
        int s0, s1;
        busy = held;
        pass = model_pass(user);
        acc  = !busy && pass && rst_at < 0;
        chk({name, "_model"}, -1, acc, exp_acc);
        if (acc) begin
            pending = 1;
            for (int i = 0; i < UDB; i++) exp_frame[8*i+:8] = pkt[34+i];
            exp_ip  = {pkt[29], pkt[28], pkt[27], pkt[26]};
            exp_mac = {pkt[11], pkt[10], pkt[9], pkt[8], pkt[7], pkt[6]};
        end
        fork
            send(0, user, rst_at, lat, s0);
            send(1, user, rst_at, 1'b0, s1);
        join
        repeat (3) @(posedge clk);
        #1;
        pending = 0;
        if (rst_at >= 0) begin
            held = 0; n_good = 0; n_busy = 0; n_err = 1;
        end else if (busy) n_busy++;
        else if (pass) begin held = 1; n_good++; end
        else n_err++;
        for (int k = 0; k < 2; k++) begin
            chk({name, "_fv"}, k, fv[k], held);
            chk({name, "_stat_good"}, k, sg[k], STATS ? n_good : 0);
            chk({name, "_stat_busy"}, k, sb[k], STATS ? n_busy : 0);
            chk({name, "_stat_err"}, k, se[k], STATS ? n_err : 0);
            if (busy) chk({name, "_busy_stalls"}, k, (k == 0) ? s0 : s1, 0);
            if (!busy && rst_at < 0)
                chk({name, "_pfa"}, k, pfa[k], {pkt[33], pkt[32], pkt[31], pkt[30]} == OWN_IP);
        end
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        held = 0;
        for (int k = 0; k < 2; k++) chk("release_fv", k, fv[k], 0);
    endtask

    // Every cycle: FRAME_VALID must track the model, and a held frame must never change.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en)
                for (int k = 0; k < 2; k++) begin
                    if (!pending) chk("cyc_fv", k, fv[k], held);
                    if (fv[k]) begin
                        chk_frame("cyc_frame", k, frame[k], exp_frame);
                        chk("cyc_src_ip", k, src_ip[k], exp_ip);
                        chk("cyc_src_mac", k, src_mac[k], exp_mac);
                    end
                end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not complete");
    end

    initial begin
        logic [47:0] dm;
        logic [15:0] et;
        logic [7:0]  vr;
        logic [31:0] di;
        int          pl;
        bit          u;
        zero_frame = '0;
        exp_frame = '0; exp_ip = '0; exp_mac = '0;
        held = 0; pending = 0; cmp_en = 0;
        n_good = 0; n_busy = 0; n_err = 0;
        frame_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; tdata[k] = '0; tkeep[k] = '0;
            tvalid[k] = 1'b0; tlast[k] = 1'b0; tuser[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_fv", k, fv[k], 0);
            chk("reset_tready", k, tready[k], 0);
            chk_frame("reset_frame", k, frame[k], zero_frame);
            chk("reset_src_ip", k, src_ip[k], 0);
            chk("reset_src_mac", k, src_mac[k], 0);
            chk("reset_stats", k, {sg[k], sb[k], se[k]}, 0);
        end
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) chk("start_then_ready", k, tready[k], 1);
        cmp_en = 1;

        build(OWN_MAC, 16'h0800, 8'h45, OWN_IP, UDB, 8'h5A);
        run("good", 1'b0, 1'b1, -1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("good_first_byte", k, frame[k][7:0], 8'h5A);
            chk("good_last_byte", k, frame[k][8*784+:8], 8'h8A);
            chk("good_src_ip", k, src_ip[k], 32'h0100A8C0);
            chk("good_src_mac", k, src_mac[k], 48'h554433221100);
        end

        build(OWN_MAC, 16'h0800, 8'h45, OWN_IP, UDB, 8'h11);
        run("busy", 1'b0, 1'b0, -1, 1'b0);
        release_frame();

        for (int i = 0; i < 7; i++) begin
            dm = OWN_MAC; et = 16'h0800; vr = 8'h45; di = OWN_IP; pl = UDB; u = 0;
            case (i)
                0: u  = 1;
                1: pl = 784;
                2: pl = 786;
                3: et = 16'h86DD;
                4: vr = 8'h46;
                5: di = 32'h0300000A;
                6: dm = 48'h990000000002;
                default: ;
            endcase
            build(dm, et, vr, di, pl, 8'(8'h20 + i));
            run($sformatf("fail%0d", i), u, 1'b0, -1, 1'b0);
        end

        build(48'hFFFFFFFFFFFF, 16'h0800, 8'h45, OWN_IP, UDB, 8'hC3);
        run("bcast", 1'b0, 1'b1, -1, 1'b0);
        release_frame();

        build(OWN_MAC, 16'h0800, 8'h45, OWN_IP, UDB, 8'h33);
        run("rst_mid", 1'b0, 1'b0, 434, 1'b0);
        build(OWN_MAC, 16'h0800, 8'h45, OWN_IP, UDB, 8'h77);
        run("after_rst", 1'b0, 1'b1, -1, 1'b0);
        for (int k = 0; k < 2; k++) chk("after_rst_first_byte", k, frame[k][7:0], 8'h77);
        release_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
